fifo_rd_stream: RTL and testbench

//  Read-side controller for the dual-clock 256x8 FIFO memory; runs entirely in the read clock domain.

---
 rtl/fifo_rd_stream_pkg.sv | 27 ++
 rtl/fifo_out_skid.sv | 73 +++++++
 rtl/fifo_rd_stream.sv | 77 +++++++
 tb/tb_fifo_rd_stream.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared read/write-side FIFO definitions: default geometry, Gray helpers,
// and the output-buffer occupancy encoding.
package fifo_rd_stream_pkg;

  localparam int unsigned FIFO_ADDR_W = 8;
  localparam int unsigned FIFO_DATA_W = 8;

  typedef enum logic [1:0] {
    OCC_NONE = 2'd0,
    OCC_ONE  = 2'd1,
    OCC_TWO  = 2'd2
  } occ_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int unsigned i = 1; i < 32; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer that absorbs the RAM read latency and presents a
// valid/ready stream; head is held stable until popped.
module fifo_out_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        occ
);

  occ_e              state, state_nxt;
  logic [DATA_W-1:0] head, head_nxt;
  logic [DATA_W-1:0] tail, tail_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OCC_NONE;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

  // A push into a full buffer cannot happen: the reader throttles issue so
  // occupancy plus in-flight never exceeds two.
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    case (state)
      OCC_NONE: begin
        if (push) begin
          head_nxt  = push_data;
          state_nxt = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_nxt  = push_data;
            state_nxt = OCC_TWO;
          end
          2'b01: state_nxt = OCC_NONE;
          2'b11: head_nxt = push_data;
          default: ;
        endcase
      end
      OCC_TWO: begin
        if (pop) begin
          head_nxt = tail;
          if (push) tail_nxt = push_data;
          else      state_nxt = OCC_ONE;
        end
      end
      default: state_nxt = OCC_NONE;
    endcase
  end

  assign m_valid = (state != OCC_NONE);
  assign m_data  = head;
  assign occ     = state;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side controller of the dual-clock FIFO: read pointer (binary/Gray),
// RAM read address, empty flag, fill level and the output stream.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = FIFO_ADDR_W,
  parameter int unsigned DATA_W = FIFO_DATA_W
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic [ADDR_W:0]   r_wptr_gray_sync,
  output logic [ADDR_W:0]   r_ptr_gray,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic              r_empty,
  output logic [ADDR_W:0]   r_level,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  localparam int unsigned PW = ADDR_W + 1;

  logic [ADDR_W:0] r_bin;
  logic [ADDR_W:0] r_bin_nxt;
  logic [ADDR_W:0] r_gray_nxt;
  logic [ADDR_W:0] w_bin;
  logic            inflight;
  logic [1:0]      occ;
  logic [2:0]      committed;
  logic            pop;
  logic            issue;

  assign r_empty    = (r_ptr_gray == r_wptr_gray_sync);
  assign r_addr     = r_bin[ADDR_W-1:0];
  assign r_bin_nxt  = r_bin + 1'b1;
  assign r_gray_nxt = PW'(bin2gray(32'(r_bin_nxt)));
  assign w_bin      = PW'(gray2bin(32'(r_wptr_gray_sync)));

  assign pop = m_valid & m_ready;

  // Words already owned by the read side after this edge: buffered plus the
  // one arriving from RAM, minus the one leaving. Never negative since pop
  // implies a buffered word.
  assign committed = 3'(occ) + 3'(inflight) - 3'(pop);
  assign issue     = !r_empty && (committed < 3'd2);

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_bin      <= '0;
      r_ptr_gray <= '0;
      r_level    <= '0;
      inflight   <= 1'b0;
    end else begin
      if (issue) begin
        r_bin      <= r_bin_nxt;
        r_ptr_gray <= r_gray_nxt;
      end
      inflight <= issue;
      r_level  <= w_bin - r_bin;
    end
  end

  fifo_out_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (r_clk),
    .rst       (r_rst),
    .push      (inflight),
    .push_data (r_data),
    .pop       (pop),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised bench for fifo_rd_stream against a queue-based model of the
// read side, with a behavioural RAM and write-side pointer source.
module tb_fifo_rd_stream;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int PMOD  = 512;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b0;
  logic [AW:0]   r_wptr_gray_sync = '0;
  logic [AW:0]   r_ptr_gray;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data = '0;
  logic          r_empty;
  logic [AW:0]   r_level;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;

  always #5 r_clk = ~r_clk;

  fifo_rd_stream #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .r_clk            (r_clk),
    .r_rst            (r_rst),
    .r_wptr_gray_sync (r_wptr_gray_sync),
    .r_ptr_gray       (r_ptr_gray),
    .r_addr           (r_addr),
    .r_data           (r_data),
    .r_empty          (r_empty),
    .r_level          (r_level),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge r_clk) r_data <= mem[r_addr];

  // reference model state
  int            rbin, wbin;
  logic [DW-1:0] q[$];
  bit            infl;
  logic [DW-1:0] infl_data;
  int            exp_level;
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_pops = 0;
  int            cyc = 0;
  int            pop_cyc[$];
  logic [DW-1:0] popped[$];
  bit            stall_prev;
  logic [DW-1:0] prev_data;
  logic [AW:0]   prev_gray;
  logic [AW-1:0] prev_addr;
  int            msb_toggles, addr_wraps;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wbin % DEPTH] = d;
    wbin++;
    r_wptr_gray_sync = (AW+1)'(gray(wbin % PMOD));
  endtask

  // Called at posedge+1 with inputs for this cycle already driven.
  task automatic step();
    bit empty, pop, issue;
    int fill;
    #1;
    empty = ((wbin % PMOD) == (rbin % PMOD));
    check("m_valid", m_valid, q.size() != 0);
    if (q.size() != 0) check("m_data", m_data, q[0]);
    check("r_empty", r_empty, empty);
    check("r_addr", r_addr, rbin % DEPTH);
    check("r_ptr_gray", r_ptr_gray, gray(rbin % PMOD));
    check("r_level", r_level, exp_level);
    if (stall_prev) check("m_data_hold", m_data, prev_data);
    if (r_ptr_gray !== prev_gray) begin
      check("gray_1bit", $countones(r_ptr_gray ^ prev_gray), 1);
      if (r_ptr_gray[AW] !== prev_gray[AW]) msb_toggles++;
    end
    if (prev_addr == 8'hFF && r_addr == 8'h00) addr_wraps++;
    prev_gray  = r_ptr_gray;
    prev_addr  = r_addr;
    stall_prev = m_valid && !m_ready;
    prev_data  = m_data;

    pop   = (q.size() != 0) && m_ready;
    fill  = q.size() + int'(infl) - int'(pop);
    issue = !empty && (fill < 2);
    if (pop) begin
      popped.push_back(q.pop_front());
      pop_cyc.push_back(cyc);
      n_pops++;
    end
    if (infl) q.push_back(infl_data);
    exp_level = (wbin - rbin) % PMOD;
    if (issue) begin
      infl_data = mem[rbin % DEPTH];
      rbin++;
    end
    infl = issue;
    cyc++;
    @(posedge r_clk);
    #1;
  endtask

  task automatic do_reset();
    r_rst   = 1'b1;
    m_ready = 1'b0;
    wbin    = 0;
    r_wptr_gray_sync = '0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_r_addr", r_addr, 0);
    check("rst_r_gray", r_ptr_gray, 0);
    check("rst_r_level", r_level, 0);
    q.delete();
    infl = 0; rbin = 0; exp_level = 0;
    stall_prev = 0; prev_gray = '0; prev_addr = '0;
    @(posedge r_clk);
    @(posedge r_clk);
    #1;
    r_rst = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, written, first_d;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(posedge r_clk);
    #1;

    // idle after reset with an empty FIFO
    do_reset();
    for (int i = 0; i < 20; i++) step();

    // single word: latency from r_empty falling to m_valid
    m_ready = 1'b1;
    first_d = $urandom_range(255);
    write_word(8'(first_d));
    step();
    step();
    check("lat_c2_valid", m_valid, 1);
    check("lat_c2_data", m_data, 8'(first_d));
    step();
    check("t2_empty", r_empty, 1);
    check("t2_gray", r_ptr_gray, 9'b001);

    // 16 preloaded words, continuous ready: back-to-back transfers
    do_reset();
    for (int i = 0; i < 16; i++) write_word(8'(i));
    m_ready = 1'b1;
    pop_cyc.delete();
    popped.delete();
    for (int i = 0; i < 24; i++) step();
    check("t3_count", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16) begin
      check("t3_no_gaps", pop_cyc[15] - pop_cyc[0], 15);
      for (int i = 0; i < 16; i++) check("t3_order", popped[i], 8'(i));
    end
    check("t3_addr", r_addr, 8'h10);

    // same 16 words with random ready and a 10-cycle stall
    do_reset();
    for (int i = 0; i < 16; i++) write_word(8'(i));
    popped.delete();
    for (int i = 0; i < 70; i++) begin
      m_ready = (i >= 5 && i < 15) ? 1'b0 : 1'($urandom_range(1));
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("t4_count", popped.size(), 16);
    for (int i = 0; i < popped.size() && i < 16; i++) check("t4_order", popped[i], 8'(i));

    // 600 words through depth 256 with a live writer, including a fill-up
    do_reset();
    base = n_pops;
    written = 0;
    msb_toggles = 0;
    addr_wraps = 0;
    for (int c = 0; c < 4000 && (n_pops - base) < 600; c++) begin
      if (written < 600 && (wbin - rbin) < DEPTH && $urandom_range(3) != 0) begin
        write_word(8'($urandom));
        written++;
      end
      m_ready = (c >= 100 && c < 400) ? 1'b0 : ($urandom_range(3) != 0);
      step();
    end
    check("t5_words", n_pops - base, 600);
    check("t5_addr_wrap", addr_wraps >= 2, 1);
    check("t5_msb_toggles", msb_toggles >= 2, 1);

    // reset while the output buffer is full
    do_reset();
    for (int i = 0; i < 8; i++) write_word(8'($urandom));
    for (int i = 0; i < 6; i++) step();
    check("t6_pre_valid", m_valid, 1);
    do_reset();
    popped.delete();
    write_word(8'hA5);
    write_word(8'h3C);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("t6_count", popped.size(), 2);
    if (popped.size() != 0) check("t6_first", popped[0], 8'hA5);
    check("t6_addr", r_addr, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
